stage_mem_bus: RTL and testbench

Memory-access pipeline stage that sits directly downstream of the execute stage and consumes its results.
- Loads and stores run over a req/ack data bus, controlled by a small FSM.
- The stage stalls the pipeline until the access completes.
- Load data is aligned and sign/zero-extended here.
- Non-memory results and hi/lo writes pass through in zero cycles; the hi/lo outputs also feed the execute stage's forwarding inputs.

---
 rtl/stage_mem_bus_pkg.sv | 63 ++++++
 rtl/stage_mem_bus_align.sv | 74 +++++++
 rtl/stage_mem_bus.sv | 194 +++++++++++++++++++
 tb/tb_stage_mem_bus.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// stage_mem_bus_pkg
//   Shared definitions for the memory-access pipeline stage:
//     - reset / write-enable constants used across the core
//     - OPERATOR_* codes for the eight load/store operators
//     - MEM_* FSM state encoding
//     - bus request bundle registered towards the data bus
//     - small operator classification helpers
// ---------------------------------------------------------------------------
package stage_mem_bus_pkg;

    localparam logic RESET_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [7:0] OPERATOR_LB  = 8'b1110_0000;
    localparam logic [7:0] OPERATOR_LH  = 8'b1110_0001;
    localparam logic [7:0] OPERATOR_LW  = 8'b1110_0011;
    localparam logic [7:0] OPERATOR_LBU = 8'b1110_0100;
    localparam logic [7:0] OPERATOR_LHU = 8'b1110_0101;
    localparam logic [7:0] OPERATOR_SB  = 8'b1110_1000;
    localparam logic [7:0] OPERATOR_SH  = 8'b1110_1001;
    localparam logic [7:0] OPERATOR_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // Everything the stage presents on the bus for one access.
    typedef struct packed {
        logic        write_enable;
        logic [31:0] address;
        logic [3:0]  byte_select;
        logic [31:0] write_data;
    } bus_req_t;

    function automatic logic is_load_op(input logic [7:0] op);
        case (op)
            OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH,
            OPERATOR_LHU, OPERATOR_LW: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        case (op)
            OPERATOR_SB, OPERATOR_SH, OPERATOR_SW: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // Halves need an even address, words a zero byte offset.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_low);
        case (op)
            OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH: return addr_low[0];
            OPERATOR_LW, OPERATOR_SW:               return addr_low != 2'b00;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_bus_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//   Combinational big-endian lane steering for the memory stage.
//   Ports:
//     operator    in  8   load/store operator
//     addr_low    in  2   byte offset within the word
//     store_data  in  32  rt value to store
//     load_data   in  32  word captured from the bus
//     byte_select out 4   lane enables, bit3 = byte offset 0
//     write_data  out 32  store data replicated across lanes
//     load_result out 32  selected lane, sign/zero extended
//   Alignment is not checked here: halves use addr_low[1] only, words use
//   the whole word regardless of addr_low.
// ---------------------------------------------------------------------------
module mem_lane_align
    import stage_mem_bus_pkg::*;
(
    input  logic [7:0]  operator,
    input  logic [1:0]  addr_low,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  byte_select,
    output logic [31:0] write_data,
    output logic [31:0] load_result
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Offset 0 is the most significant byte of the bus word.
    always_comb begin
        load_byte = load_data[31:24];
        case (addr_low)
            2'd0:    load_byte = load_data[31:24];
            2'd1:    load_byte = load_data[23:16];
            2'd2:    load_byte = load_data[15:8];
            default: load_byte = load_data[7:0];
        endcase
        load_half = addr_low[1] ? load_data[15:0] : load_data[31:16];
    end

    always_comb begin
        byte_select = 4'b0000;
        write_data  = 32'h0000_0000;
        case (operator)
            OPERATOR_LB, OPERATOR_LBU, OPERATOR_SB: begin
                byte_select = 4'b1000 >> addr_low;
                write_data  = {4{store_data[7:0]}};
            end
            OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH: begin
                byte_select = addr_low[1] ? 4'b0011 : 4'b1100;
                write_data  = {2{store_data[15:0]}};
            end
            OPERATOR_LW, OPERATOR_SW: begin
                byte_select = 4'b1111;
                write_data  = store_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_result = 32'h0000_0000;
        case (operator)
            OPERATOR_LB:  load_result = {{24{load_byte[7]}}, load_byte};
            OPERATOR_LBU: load_result = {24'h00_0000, load_byte};
            OPERATOR_LH:  load_result = {{16{load_half[15]}}, load_half};
            OPERATOR_LHU: load_result = {16'h0000, load_half};
            OPERATOR_LW:  load_result = load_data;
            default:      ;
        endcase
    end

endmodule

// File: rtl/stage_mem_bus.sv
// ---------------------------------------------------------------------------
// stage_mem_bus
//   Memory-access pipeline stage downstream of execute. Loads/stores run
//   over a req/ack bus under an IDLE/BUSY/DONE FSM and stall upstream until
//   the access completes; everything else passes through combinationally.
//   Ports:
//     clock, reset                    rising-edge clock, sync active-high reset
//     operator, memory_address,       access description from execute
//     store_data
//     register_*_i                    GPR and hi/lo results from execute
//     register_*_o                    GPR and hi/lo results to writeback
//                                     (hi/lo also feed execute forwarding)
//     stall_request                   holds all upstream stages
//     bus_*                           req/ack data bus
//     address_error                   misaligned access flag (option only)
//   Build option MEM_ALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW accesses are
//   dropped (no bus access, no stall, no GPR write) and flagged on
//   address_error for that IDLE cycle.
// ---------------------------------------------------------------------------
module stage_mem_bus
    import stage_mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            operator,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [31:0]           store_data,
    input  logic                  register_write_enable_i,
    input  logic [4:0]            register_write_address_i,
    input  logic [31:0]           register_write_data_i,
    input  logic                  register_hi_write_enable_i,
    input  logic                  register_lo_write_enable_i,
    input  logic [31:0]           register_hi_write_data_i,
    input  logic [31:0]           register_lo_write_data_i,
    output logic                  register_write_enable_o,
    output logic [4:0]            register_write_address_o,
    output logic [31:0]           register_write_data_o,
    output logic                  register_hi_write_enable_o,
    output logic                  register_lo_write_enable_o,
    output logic [31:0]           register_hi_write_data_o,
    output logic [31:0]           register_lo_write_data_o,
    output logic                  stall_request,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  address_error,
`endif
    output logic                  bus_request,
    output logic                  bus_write_enable,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [3:0]            bus_byte_select,
    output logic [31:0]           bus_write_data,
    input  logic [31:0]           bus_read_data,
    input  logic                  bus_acknowledge
);

    mem_state_e  state_q, state_d;
    bus_req_t    bus_req_q, bus_req_d;
    logic        bus_request_q, bus_request_d;
    logic [31:0] load_data_q, load_data_d;

    logic [3:0]  lane_select;
    logic [31:0] lane_write_data;
    logic [31:0] lane_load_result;

    logic        op_load, op_store, op_mem, misaligned, access_start;

    mem_lane_align u_align (
        .operator    (operator),
        .addr_low    (memory_address[1:0]),
        .store_data  (store_data),
        .load_data   (load_data_q),
        .byte_select (lane_select),
        .write_data  (lane_write_data),
        .load_result (lane_load_result)
    );

    assign op_load  = is_load_op(operator);
    assign op_store = is_store_op(operator);
    assign op_mem   = op_load | op_store;
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = op_mem & is_misaligned(operator, memory_address[1:0]);
`else
    assign misaligned = 1'b0;
`endif
    assign access_start = op_mem & ~misaligned;

    // Next-state and bus register update.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_request_d = bus_request_q;
        load_data_d   = load_data_q;
        case (state_q)
            MEM_IDLE: begin
                if (access_start) begin
                    state_d                = MEM_BUSY;
                    bus_request_d          = 1'b1;
                    bus_req_d.write_enable = op_store;
                    bus_req_d.address      = {memory_address[31:2], 2'b00};
                    bus_req_d.byte_select  = lane_select;
                    bus_req_d.write_data   = lane_write_data;
                end
            end
            MEM_BUSY: begin
                if (bus_acknowledge) begin
                    state_d       = MEM_DONE;
                    bus_request_d = 1'b0;
                    load_data_d   = bus_read_data;
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
        // Reset abandons any access in flight; a late ack lands in IDLE.
        if (reset == RESET_ENABLE) begin
            state_d       = MEM_IDLE;
            bus_req_d     = '0;
            bus_request_d = 1'b0;
            load_data_d   = 32'h0000_0000;
        end
    end

    always_ff @(posedge clock) begin
        state_q       <= state_d;
        bus_req_q     <= bus_req_d;
        bus_request_q <= bus_request_d;
        load_data_q   <= load_data_d;
    end

    // Stage outputs. While a memory op is stalled (IDLE start cycle and
    // BUSY) the GPR write is held off so writeback sees a bubble; the
    // write happens once, in DONE, with the extracted load data.
    always_comb begin
        register_write_enable_o    = register_write_enable_i;
        register_write_address_o   = register_write_address_i;
        register_write_data_o      = register_write_data_i;
        register_hi_write_enable_o = register_hi_write_enable_i;
        register_lo_write_enable_o = register_lo_write_enable_i;
        register_hi_write_data_o   = register_hi_write_data_i;
        register_lo_write_data_o   = register_lo_write_data_i;
        stall_request              = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        address_error              = 1'b0;
`endif
        case (state_q)
            MEM_IDLE: begin
                if (access_start) begin
                    stall_request           = 1'b1;
                    register_write_enable_o = WRITE_DISABLE;
                end else if (misaligned) begin
                    register_write_enable_o = WRITE_DISABLE;
`ifdef MEM_ALIGN_CHECK_EN
                    address_error           = 1'b1;
`endif
                end
            end
            MEM_BUSY: begin
                stall_request           = 1'b1;
                register_write_enable_o = WRITE_DISABLE;
            end
            MEM_DONE: begin
                if (op_load) begin
                    register_write_data_o = lane_load_result;
                end else begin
                    register_write_enable_o = WRITE_DISABLE;
                end
            end
            default: ;
        endcase
        if (reset == RESET_ENABLE) begin
            register_write_enable_o    = WRITE_DISABLE;
            register_write_address_o   = 5'd0;
            register_write_data_o      = 32'h0000_0000;
            register_hi_write_enable_o = WRITE_DISABLE;
            register_lo_write_enable_o = WRITE_DISABLE;
            register_hi_write_data_o   = 32'h0000_0000;
            register_lo_write_data_o   = 32'h0000_0000;
            stall_request              = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            address_error              = 1'b0;
`endif
        end
    end

    // Registered bus outputs, forced low during reset so nothing stale
    // shows before the first reset edge.
    assign bus_request      = bus_request_q & ~reset;
    assign bus_write_enable = bus_req_q.write_enable & ~reset;
    assign bus_address      = reset ? '0 : bus_req_q.address;
    assign bus_byte_select  = reset ? 4'b0000 : bus_req_q.byte_select;
    assign bus_write_data   = reset ? 32'h0000_0000 : bus_req_q.write_data;

endmodule

// File: tb/tb_stage_mem_bus.sv
module tb_stage_mem_bus;
    import stage_mem_bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  operator;
    logic [31:0] memory_address, store_data;
    logic        register_write_enable_i;
    logic [4:0]  register_write_address_i;
    logic [31:0] register_write_data_i;
    logic        register_hi_write_enable_i, register_lo_write_enable_i;
    logic [31:0] register_hi_write_data_i, register_lo_write_data_i;
    logic        register_write_enable_o;
    logic [4:0]  register_write_address_o;
    logic [31:0] register_write_data_o;
    logic        register_hi_write_enable_o, register_lo_write_enable_o;
    logic [31:0] register_hi_write_data_o, register_lo_write_data_o;
    logic        stall_request;
`ifdef MEM_ALIGN_CHECK_EN
    logic        address_error;
`endif
    logic        bus_request, bus_write_enable;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_select;
    logic [31:0] bus_write_data, bus_read_data;
    logic        bus_acknowledge;

    stage_mem_bus #(.ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .operator(operator),
        .memory_address(memory_address), .store_data(store_data),
        .register_write_enable_i(register_write_enable_i),
        .register_write_address_i(register_write_address_i),
        .register_write_data_i(register_write_data_i),
        .register_hi_write_enable_i(register_hi_write_enable_i),
        .register_lo_write_enable_i(register_lo_write_enable_i),
        .register_hi_write_data_i(register_hi_write_data_i),
        .register_lo_write_data_i(register_lo_write_data_i),
        .register_write_enable_o(register_write_enable_o),
        .register_write_address_o(register_write_address_o),
        .register_write_data_o(register_write_data_o),
        .register_hi_write_enable_o(register_hi_write_enable_o),
        .register_lo_write_enable_o(register_lo_write_enable_o),
        .register_hi_write_data_o(register_hi_write_data_o),
        .register_lo_write_data_o(register_lo_write_data_o),
        .stall_request(stall_request),
`ifdef MEM_ALIGN_CHECK_EN
        .address_error(address_error),
`endif
        .bus_request(bus_request), .bus_write_enable(bus_write_enable),
        .bus_address(bus_address), .bus_byte_select(bus_byte_select),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
        .bus_acknowledge(bus_acknowledge)
    );

    always #5 clock = ~clock;

    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    int checks = 0;
    int failures = 0;

    // Per-cycle expectations, written by the driver after each rising edge.
    logic        exp_valid = 1'b0;
    logic        exp_stall, exp_req, exp_we_o, exp_data_chk, exp_bus_chk, exp_aerr;
    logic [4:0]  exp_addr_o;
    logic [31:0] exp_data_o;
    logic        exp_hi_we, exp_lo_we;
    logic [31:0] exp_hi_d, exp_lo_d;
    logic        exp_bwe;
    logic [31:0] exp_baddr, exp_bwdata;
    logic [3:0]  exp_bsel;

    // Values observed during the most recent operation, for literal checks.
    int          cap_stall_cycles;
    logic        cap_req_seen, cap_bwe, cap_done_we, cap_we0, cap_stall0, cap_aerr;
    logic [31:0] cap_baddr, cap_bwdata, cap_done_data, cap_data0;
    logic [3:0]  cap_bsel;
    logic [4:0]  cap_addr0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [7:0] op);
        case (op)
            OPERATOR_LB, OPERATOR_LBU, OPERATOR_SB: return 1;
            OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH: return 2;
            OPERATOR_LW, OPERATOR_SW:               return 4;
            default:                                return 0;
        endcase
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return op == OPERATOR_SB || op == OPERATOR_SH || op == OPERATOR_SW;
    endfunction

    // Byte offset of the first lane touched (alignment bits below the
    // access size are ignored).
    function automatic int m_first(input logic [7:0] op, input logic [31:0] addr);
        int sz = m_size(op);
        if (sz == 4) return 0;
        if (sz == 2) return int'(addr[1]) * 2;
        return int'(addr[1:0]);
    endfunction

    function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        int sz = m_size(op);
        return (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
`else
        return (op == 8'hxx);
`endif
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        logic [3:0] s = 4'b0000;
        int f = m_first(op, addr);
        int sz = m_size(op);
        for (int i = 0; i < 4; i++)
            if (i >= f && i < f + sz) s[3-i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] sd);
        logic [31:0] w = 32'h0;
        int sz = m_size(op);
        for (int i = 0; i < 4; i++)
            w |= ((sd >> (8 * (sz - 1 - (i % sz)))) & 32'hFF) << (8 * (3 - i));
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int sz = m_size(op);
        int f = m_first(op, addr);
        logic [31:0] v = rd >> (8 * (4 - f - sz));
        if (sz == 1) begin
            v &= 32'hFF;
            if (op == OPERATOR_LB && v >= 32'h80) v |= 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v &= 32'hFFFF;
            if (op == OPERATOR_LH && v >= 32'h8000) v |= 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (exp_valid) begin
            check("stall_request", {31'b0, stall_request}, {31'b0, exp_stall});
            check("bus_request", {31'b0, bus_request}, {31'b0, exp_req});
            check("reg_we_o", {31'b0, register_write_enable_o}, {31'b0, exp_we_o});
            if (exp_data_chk) begin
                check("reg_addr_o", {27'b0, register_write_address_o}, {27'b0, exp_addr_o});
                check("reg_data_o", register_write_data_o, exp_data_o);
            end
            check("hi_we_o", {31'b0, register_hi_write_enable_o}, {31'b0, exp_hi_we});
            check("lo_we_o", {31'b0, register_lo_write_enable_o}, {31'b0, exp_lo_we});
            check("hi_data_o", register_hi_write_data_o, exp_hi_d);
            check("lo_data_o", register_lo_write_data_o, exp_lo_d);
            if (exp_bus_chk) begin
                check("bus_we", {31'b0, bus_write_enable}, {31'b0, exp_bwe});
                check("bus_address", bus_address, exp_baddr);
                check("bus_sel", {28'b0, bus_byte_select}, {28'b0, exp_bsel});
                check("bus_wdata", bus_write_data, exp_bwdata);
            end
`ifdef MEM_ALIGN_CHECK_EN
            check("address_error", {31'b0, address_error}, {31'b0, exp_aerr});
`endif
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive_hilo(input bit in_reset);
        register_hi_write_enable_i = 1'($urandom);
        register_lo_write_enable_i = 1'($urandom);
        register_hi_write_data_i   = $urandom;
        register_lo_write_data_i   = $urandom;
        exp_hi_we = in_reset ? 1'b0 : register_hi_write_enable_i;
        exp_lo_we = in_reset ? 1'b0 : register_lo_write_enable_i;
        exp_hi_d  = in_reset ? 32'h0 : register_hi_write_data_i;
        exp_lo_d  = in_reset ? 32'h0 : register_lo_write_data_i;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Expectations for a cycle where the stage must be a plain copy.
    task automatic exp_passthrough();
        exp_stall = 1'b0; exp_req = 1'b0; exp_bus_chk = 1'b0; exp_aerr = 1'b0;
        exp_we_o = register_write_enable_i; exp_data_chk = 1'b1;
        exp_addr_o = register_write_address_i; exp_data_o = register_write_data_i;
    endtask

    // Runs one operation to completion. wait_cycles = cycles the bus
    // withholds ack after the request is raised. Assumes called right
    // after a rising edge (#1) with the stage idle.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input bit we, input logic [4:0] rd, input logic [31:0] wd,
                          input logic [31:0] rdata, input int wait_cycles);
        bit mem = m_size(op) != 0;
        bit mis = mem && m_misaligned(op, addr);
        int last = (mem && !mis) ? wait_cycles + 2 : 0;
        operator = op; memory_address = addr; store_data = sd;
        register_write_enable_i = we; register_write_address_i = rd;
        register_write_data_i = wd;
        cap_stall_cycles = 0; cap_req_seen = 1'b0;
        for (int k = 0; k <= last; k++) begin
            drive_hilo(1'b0);
            // ack only matters in the BUSY cycle that ends the wait;
            // spurious acks elsewhere must be ignored
            if (mem && !mis && k == wait_cycles + 1) begin
                bus_acknowledge = 1'b1; bus_read_data = rdata;
            end else begin
                bus_acknowledge = ((k == 0 || k == last) && $urandom_range(0, 1) == 1);
                bus_read_data = $urandom;
            end
            exp_passthrough();
            if (mis) begin
                exp_we_o = 1'b0; exp_aerr = 1'b1;
            end else if (mem) begin
                exp_stall = (k <= wait_cycles + 1);
                exp_req   = (k >= 1 && k <= wait_cycles + 1);
                exp_bus_chk = exp_req;
                exp_bwe   = m_is_store(op);
                exp_baddr = addr & 32'hFFFF_FFFC;
                exp_bsel  = m_sel(op, addr);
                exp_bwdata = m_wdata(op, sd);
                if (k < last) begin
                    exp_we_o = 1'b0; exp_data_chk = 1'b0;
                end else if (m_is_store(op)) begin
                    exp_we_o = 1'b0; exp_data_chk = 1'b0;
                end else begin
                    exp_data_o = m_load(op, addr, rdata);
                end
            end
            exp_valid = 1'b1;
            @(negedge clock);
            if (stall_request) cap_stall_cycles++;
            if (k == 0) begin
                cap_we0 = register_write_enable_o; cap_addr0 = register_write_address_o;
                cap_data0 = register_write_data_o; cap_stall0 = stall_request;
`ifdef MEM_ALIGN_CHECK_EN
                cap_aerr = address_error;
`else
                cap_aerr = 1'b0;
`endif
            end
            if (bus_request) begin
                cap_req_seen = 1'b1; cap_baddr = bus_address; cap_bsel = bus_byte_select;
                cap_bwdata = bus_write_data; cap_bwe = bus_write_enable;
            end
            if (k == last) begin
                cap_done_data = register_write_data_o; cap_done_we = register_write_enable_o;
            end
            next_cycle();
        end
        bus_acknowledge = 1'b0;
    endtask

    localparam logic [7:0] MEM_OPS [8] = '{OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH, OPERATOR_LHU,
                                           OPERATOR_LW, OPERATOR_SB, OPERATOR_SH, OPERATOR_SW};

    initial begin
        logic [7:0] op;
        reset = 1'b1;
        operator = OPERATOR_LW; memory_address = 32'h1234_5678; store_data = $urandom;
        register_write_enable_i = 1'b1; register_write_address_i = 5'd9;
        register_write_data_i = 32'hCAFE_0001; bus_read_data = $urandom; bus_acknowledge = 1'b1;
        cap_aerr = 1'b0;
        // reset state: every output zero even with live inputs
        #1;
        for (int i = 0; i < 3; i++) begin
            drive_hilo(1'b1);
            exp_stall = 0; exp_req = 0; exp_we_o = 0; exp_data_chk = 1; exp_addr_o = 0;
            exp_data_o = 0; exp_bus_chk = 1; exp_bwe = 0; exp_baddr = 0; exp_bsel = 0;
            exp_bwdata = 0; exp_aerr = 0; exp_valid = 1'b1;
            next_cycle();
        end
        reset = 1'b0; bus_acknowledge = 1'b0;

        // pass-through ADD
        run_op(OP_ADD, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0000_0007, 32'h0, 0);
        check("add_we", {31'b0, cap_we0}, 32'd1);
        check("add_rd", {27'b0, cap_addr0}, 32'd5);
        check("add_data", cap_data0, 32'h0000_0007);
        check("add_stall", {31'b0, cap_stall0}, 32'd0);
        check("add_req", {31'b0, cap_req_seen}, 32'd0);

        // LW with two ack-wait cycles
        run_op(OPERATOR_LW, 32'h0000_0100, 32'h0, 1'b1, 5'd3, 32'h5555_5555, 32'hDEAD_BEEF, 2);
        check("lw_addr", cap_baddr, 32'h0000_0100);
        check("lw_sel", {28'b0, cap_bsel}, 32'hF);
        check("lw_stall_cycles", cap_stall_cycles, 32'd4);
        check("lw_done_data", cap_done_data, 32'hDEAD_BEEF);

        // byte loads from the last lane
        run_op(OPERATOR_LB, 32'h0000_0103, 32'h0, 1'b1, 5'd4, 32'h0, 32'h1122_33F4, 0);
        check("lb_data", cap_done_data, 32'hFFFF_FFF4);
        check("lb_sel", {28'b0, cap_bsel}, 32'h1);
        run_op(OPERATOR_LBU, 32'h0000_0103, 32'h0, 1'b1, 5'd4, 32'h0, 32'h1122_33F4, 0);
        check("lbu_data", cap_done_data, 32'h0000_00F4);
        check("lbu_sel", {28'b0, cap_bsel}, 32'h1);

        // halfword store to the low half
        run_op(OPERATOR_SH, 32'h0000_0102, 32'h0000_ABCD, 1'b1, 5'd6, 32'h0, 32'h0, 1);
        check("sh_wdata", cap_bwdata, 32'hABCD_ABCD);
        check("sh_sel", {28'b0, cap_bsel}, 32'h3);
        check("sh_bwe", {31'b0, cap_bwe}, 32'd1);
        check("sh_done_we", {31'b0, cap_done_we}, 32'd0);

        // reset while BUSY, then a stray ack
        operator = OPERATOR_LW; memory_address = 32'h0000_0200; store_data = 32'h0;
        register_write_enable_i = 1'b1; register_write_address_i = 5'd7;
        register_write_data_i = 32'h0;
        drive_hilo(1'b0); exp_passthrough();
        exp_stall = 1; exp_we_o = 0; exp_data_chk = 0;
        next_cycle();
        drive_hilo(1'b0); exp_req = 1; exp_bus_chk = 1; exp_bwe = 0;
        exp_baddr = 32'h0000_0200; exp_bsel = 4'hF; exp_bwdata = 32'h0;
        next_cycle();
        reset = 1'b1; drive_hilo(1'b1);
        exp_stall = 0; exp_req = 0; exp_we_o = 0; exp_data_chk = 1; exp_addr_o = 0;
        exp_data_o = 0; exp_bus_chk = 1; exp_baddr = 0; exp_bsel = 0;
        next_cycle();
        reset = 1'b0; operator = OP_ADD; register_write_enable_i = 1'b0;
        bus_acknowledge = 1'b1; bus_read_data = 32'h8765_4321;
        for (int i = 0; i < 2; i++) begin
            drive_hilo(1'b0); exp_passthrough();
            @(negedge clock);
            check("rst_req", {31'b0, bus_request}, 32'd0);
            check("rst_stall", {31'b0, stall_request}, 32'd0);
            check("rst_we", {31'b0, register_write_enable_o}, 32'd0);
            next_cycle();
            bus_acknowledge = 1'b0;
        end

`ifdef MEM_ALIGN_CHECK_EN
        run_op(OPERATOR_LW, 32'h0000_0102, 32'h0, 1'b1, 5'd8, 32'h0, 32'h0, 0);
        check("mis_aerr", {31'b0, cap_aerr}, 32'd1);
        check("mis_req", {31'b0, cap_req_seen}, 32'd0);
        check("mis_stall", {31'b0, cap_stall0}, 32'd0);
        check("mis_we", {31'b0, cap_we0}, 32'd0);
`endif

        // randomized mix
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                op = 8'($urandom);
                if (m_size(op) != 0) op = OP_ADD;
            end else begin
                op = MEM_OPS[$urandom_range(0, 7)];
            end
            run_op(op, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3));
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
